// File: rtl/maf_pkg.sv
// Shared definitions for the MAF normalization datapath: default widths,
// mode encodings and the full/dual-lane mode decode.
package maf_pkg;

    localparam int SUM_W_DEF = 48;
    localparam int CNT_W_DEF = 6;
    localparam int EXP_W_DEF = 10;

    localparam logic [2:0] MODE_FULL0 = 3'b000;
    localparam logic [2:0] MODE_FULL2 = 3'b010;

    // Only two encodings select the single full-width lane; all others are dual-lane.
    function automatic logic is_full_mode(input logic [2:0] cont);
        return (cont == MODE_FULL0) || (cont == MODE_FULL2);
    endfunction

endpackage

// File: rtl/maf_norm_shift_if.sv
// Upstream/downstream handshake and data bundle of the normalization stage.
// The slave modport is the DUT view, the master modport is the driver view.
interface maf_norm_shift_if #(
    parameter int SUM_W = 48,
    parameter int CNT_W = 6,
    parameter int EXP_W = 10
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           cont;
    logic [SUM_W-1:0]     sum_in;
    logic [2*CNT_W-1:0]   lz_cnt;
    logic [1:0]           revising;
    logic [2*EXP_W-1:0]   exp_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [SUM_W-1:0]     sum_out;
    logic [2*EXP_W-1:0]   exp_out;
    logic [1:0]           zero_out;
    logic [1:0]           uflow_out;
    logic [2:0]           cont_out;

    modport slave (
        input  in_valid, cont, sum_in, lz_cnt, revising, exp_in, out_ready,
        output in_ready, out_valid, sum_out, exp_out, zero_out, uflow_out, cont_out
    );

    modport master (
        output in_valid, cont, sum_in, lz_cnt, revising, exp_in, out_ready,
        input  in_ready, out_valid, sum_out, exp_out, zero_out, uflow_out, cont_out
    );
endinterface

// File: rtl/maf_norm_lane.sv
// One normalization lane of width W: clamped coarse shift in stage 1,
// one-bit fine correction, exponent adjust and zero/underflow flags in stage 2.
// Pipeline movement is controlled by the parent through ld_p1/ld_p2.
module maf_norm_lane #(
    parameter int W     = 24,
    parameter int CNT_W = 6,
    parameter int EXP_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_p1,
    input  logic             ld_p2,
    input  logic [W-1:0]     raw_sum,
    input  logic [CNT_W-1:0] lz,
    input  logic             rev,
    input  logic [EXP_W-1:0] base_exp,
    output logic [W-1:0]     norm_sum,
    output logic [EXP_W-1:0] norm_exp,
    output logic             zero,
    output logic             uflow
);

    localparam logic [CNT_W-1:0] MAX_SHIFT = CNT_W'(W - 1);

    // Exponent minus total shift, evaluated one bit wider so a negative result is visible.
    function automatic logic signed [EXP_W:0] adj_exp(input logic [EXP_W-1:0] e,
                                                      input logic [CNT_W-1:0] s,
                                                      input logic c);
        logic signed [EXP_W:0] ext_e;
        logic signed [EXP_W:0] ext_s;
        logic signed [EXP_W:0] ext_c;
        ext_e = $signed({e[EXP_W-1], e});
        ext_s = $signed({{(EXP_W + 1 - CNT_W){1'b0}}, s});
        ext_c = $signed({{EXP_W{1'b0}}, c});
        return ext_e - ext_s - ext_c;
    endfunction

    logic [CNT_W-1:0] shift;
    logic [W-1:0]     shifted;
    logic             raw_zero;

    logic [W-1:0]     sum_p1;
    logic [CNT_W-1:0] shift_p1;
    logic             rev_p1;
    logic [EXP_W-1:0] exp_p1;
    logic             zero_p1;

    logic                  corr;
    logic [W-1:0]          fine_sum;
    logic signed [EXP_W:0] exp_adj;

    // Stage 1: clamp the anticipated count to the lane and apply the coarse shift.
    always_comb begin
        shift    = (lz > MAX_SHIFT) ? MAX_SHIFT : lz;
        shifted  = raw_sum << shift;
        raw_zero = (raw_sum == '0);
    end

    // Stage 1 registers: data only, qualified by the parent's valid.
    always_ff @(posedge clk) begin
        if (ld_p1) begin
            sum_p1   <= shifted;
            shift_p1 <= shift;
            rev_p1   <= rev;
            exp_p1   <= base_exp;
            zero_p1  <= raw_zero;
        end
    end

    // Stage 2: extra shift only when the anticipator asks for it and the MSB is still clear.
    always_comb begin
        corr     = rev_p1 && !sum_p1[W-1] && !zero_p1;
        fine_sum = corr ? {sum_p1[W-2:0], 1'b0} : sum_p1;
        exp_adj  = adj_exp(exp_p1, shift_p1, corr);
    end

    // Stage 2 result registers; a zero lane keeps its exponent and never underflows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            norm_sum <= '0;
            norm_exp <= '0;
            zero     <= 1'b0;
            uflow    <= 1'b0;
        end else if (ld_p2) begin
            norm_sum <= zero_p1 ? '0 : fine_sum;
            norm_exp <= zero_p1 ? exp_p1 : exp_adj[EXP_W-1:0];
            zero     <= zero_p1;
            uflow    <= zero_p1 ? 1'b0 : exp_adj[EXP_W];
        end
    end

endmodule

// File: rtl/maf_norm_shift.sv
// MAF normalization stage: two-stage valid/ready pipeline that runs one
// full-width lane and two half-width lanes in parallel and selects the
// result set by the mode that travelled with the beat.
module maf_norm_shift
    import maf_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    maf_norm_shift_if.slave  bus
);

    localparam int H = SUM_W / 2;

    logic s1_valid, s2_valid, s1_adv, accept, ld_p2;
    logic [2:0] cont_p1, cont_p2;

    logic [SUM_W-1:0] full_sum;
    logic [EXP_W-1:0] full_exp;
    logic             full_zero, full_uflow;
    logic [H-1:0]     lo_sum, hi_sum;
    logic [EXP_W-1:0] lo_exp, hi_exp;
    logic             lo_zero, hi_zero, lo_uflow, hi_uflow;

    assign s1_adv       = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s1_adv;
    assign accept       = bus.in_valid && bus.in_ready;
    assign ld_p2        = s1_valid && s1_adv;
    assign bus.out_valid = s2_valid;
    assign bus.cont_out  = cont_p2;

    // Pipeline occupancy and the mode tag that reaches the output mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            cont_p2  <= '0;
        end else begin
            if (bus.in_ready) s1_valid <= bus.in_valid;
            if (s1_adv)       s2_valid <= s1_valid;
            if (ld_p2)        cont_p2  <= cont_p1;
        end
    end

    // Stage 1 mode tag, data only.
    always_ff @(posedge clk) begin
        if (accept) cont_p1 <= bus.cont;
    end

    maf_norm_lane #(.W(SUM_W), .CNT_W(CNT_W), .EXP_W(EXP_W)) u_full (
        .clk(clk), .rst(rst), .ld_p1(accept), .ld_p2(ld_p2),
        .raw_sum(bus.sum_in), .lz(bus.lz_cnt[CNT_W-1:0]), .rev(bus.revising[0]),
        .base_exp(bus.exp_in[EXP_W-1:0]),
        .norm_sum(full_sum), .norm_exp(full_exp), .zero(full_zero), .uflow(full_uflow)
    );

    maf_norm_lane #(.W(H), .CNT_W(CNT_W), .EXP_W(EXP_W)) u_lane0 (
        .clk(clk), .rst(rst), .ld_p1(accept), .ld_p2(ld_p2),
        .raw_sum(bus.sum_in[H-1:0]), .lz(bus.lz_cnt[CNT_W-1:0]), .rev(bus.revising[0]),
        .base_exp(bus.exp_in[EXP_W-1:0]),
        .norm_sum(lo_sum), .norm_exp(lo_exp), .zero(lo_zero), .uflow(lo_uflow)
    );

    maf_norm_lane #(.W(H), .CNT_W(CNT_W), .EXP_W(EXP_W)) u_lane1 (
        .clk(clk), .rst(rst), .ld_p1(accept), .ld_p2(ld_p2),
        .raw_sum(bus.sum_in[SUM_W-1:H]), .lz(bus.lz_cnt[2*CNT_W-1:CNT_W]), .rev(bus.revising[1]),
        .base_exp(bus.exp_in[2*EXP_W-1:EXP_W]),
        .norm_sum(hi_sum), .norm_exp(hi_exp), .zero(hi_zero), .uflow(hi_uflow)
    );

    // Result select; lane1 fields read as zero in full-width mode.
    always_comb begin
        bus.sum_out   = {hi_sum, lo_sum};
        bus.exp_out   = {hi_exp, lo_exp};
        bus.zero_out  = {hi_zero, lo_zero};
        bus.uflow_out = {hi_uflow, lo_uflow};
        if (is_full_mode(cont_p2)) begin
            bus.sum_out   = full_sum;
            bus.exp_out   = {{EXP_W{1'b0}}, full_exp};
            bus.zero_out  = {1'b0, full_zero};
            bus.uflow_out = {1'b0, full_uflow};
        end
    end

endmodule

// File: tb/tb_maf_norm_shift.sv
// Directed bench for maf_norm_shift: a table of hand-computed vectors streamed
// back-to-back, then backpressure and mid-flight reset sequences.
module tb_maf_norm_shift;

    typedef struct {
        logic [2:0]  cont;
        logic [47:0] sum;
        logic [11:0] cnt;
        logic [1:0]  rev;
        logic [19:0] exp;
        logic [47:0] e_sum;
        logic [19:0] e_exp;
        logic [1:0]  e_zero;
        logic [1:0]  e_uflow;
    } vec_t;

    localparam int NV = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maf_norm_shift_if bus ();
    maf_norm_shift dut (.clk(clk), .rst(rst), .bus(bus));

    vec_t vecs [NV];
    int n_vec = 0;
    int n_bad = 0;

    function automatic vec_t mk(input logic [2:0] c, input logic [47:0] s, input logic [11:0] n,
                                input logic [1:0] r, input logic [19:0] e, input logic [47:0] es,
                                input logic [19:0] ee, input logic [1:0] ez, input logic [1:0] eu);
        vec_t v;
        v.cont = c; v.sum = s; v.cnt = n; v.rev = r; v.exp = e;
        v.e_sum = es; v.e_exp = ee; v.e_zero = ez; v.e_uflow = eu;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid = 1'b1;
        bus.cont     = v.cont;
        bus.sum_in   = v.sum;
        bus.lz_cnt   = v.cnt;
        bus.revising = v.rev;
        bus.exp_in   = v.exp;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.cont     = '0;
        bus.sum_in   = '0;
        bus.lz_cnt   = '0;
        bus.revising = '0;
        bus.exp_in   = '0;
    endtask

    task automatic check_out(input vec_t v, input string tag);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, ".sum"},   64'(bus.sum_out),   64'(v.e_sum));
        chk({tag, ".exp"},   64'(bus.exp_out),   64'(v.e_exp));
        chk({tag, ".zero"},  64'(bus.zero_out),  64'(v.e_zero));
        chk({tag, ".uflow"}, 64'(bus.uflow_out), 64'(v.e_uflow));
        chk({tag, ".cont"},  64'(bus.cont_out),  64'(v.cont));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".sum"},   64'(bus.sum_out),   64'd0);
        chk({tag, ".exp"},   64'(bus.exp_out),   64'd0);
        chk({tag, ".zero"},  64'(bus.zero_out),  64'd0);
        chk({tag, ".uflow"}, 64'(bus.uflow_out), 64'd0);
        chk({tag, ".cont"},  64'(bus.cont_out),  64'd0);
    endtask

    initial begin
        // full mode, coarse short by one, corrected
        vecs[0] = mk(3'b000, 48'h0000_0F00_0000, {6'd0, 6'd19}, 2'b01, {10'd0, 10'd100},
                     48'hF000_0000_0000, {10'd0, 10'd80}, 2'b00, 2'b00);
        // full mode (010), exact count, no correction
        vecs[1] = mk(3'b010, 48'h0000_0F00_0000, {6'd0, 6'd20}, 2'b00, {10'd0, 10'd100},
                     48'hF000_0000_0000, {10'd0, 10'd80}, 2'b00, 2'b00);
        // dual mode, both lanes corrected, no cross-lane bits
        vecs[2] = mk(3'b001, {24'h000001, 24'h400000}, {6'd22, 6'd0}, 2'b11, {10'd30, 10'd5},
                     {24'h800000, 24'h800000}, {10'd7, 10'd4}, 2'b00, 2'b00);
        // full mode zero: exponent passes through
        vecs[3] = mk(3'b000, 48'h0, {6'd0, 6'd5}, 2'b01, {10'd0, 10'd12},
                     48'h0, {10'd0, 10'd12}, 2'b01, 2'b00);
        // full mode underflow: 3 - 47 = -44 wrapped to 10 bits
        vecs[4] = mk(3'b000, 48'h1, {6'd0, 6'd47}, 2'b00, {10'd0, 10'd3},
                     48'h8000_0000_0000, {10'd0, 10'h3D4}, 2'b00, 2'b01);
        // full mode count clamp 63 -> 47
        vecs[5] = mk(3'b000, 48'h1, {6'd0, 6'd63}, 2'b00, {10'd0, 10'd100},
                     48'h8000_0000_0000, {10'd0, 10'd53}, 2'b00, 2'b00);
        // revising set but MSB already 1: no extra shift
        vecs[6] = mk(3'b010, 48'h8000_0000_0001, {6'd0, 6'd0}, 2'b01, {10'd0, 10'd9},
                     48'h8000_0000_0001, {10'd0, 10'd9}, 2'b00, 2'b00);
        // dual: lane1 zero, lane0 count clamped 40 -> 23
        vecs[7] = mk(3'b111, {24'h000000, 24'h000001}, {6'd3, 6'd40}, 2'b11, {10'd77, 10'd50},
                     {24'h000000, 24'h800000}, {10'd77, 10'd27}, 2'b10, 2'b00);
        // dual: lane0 top bits dropped inside lane, lane1 underflow 10 - 16 = -6
        vecs[8] = mk(3'b100, {24'h0000F0, 24'hFFFFFF}, {6'd16, 6'd4}, 2'b00, {10'd10, 10'd20},
                     {24'hF00000, 24'hFFFFF0}, {10'h3FA, 10'd16}, 2'b00, 2'b10);
        // full mode ignores lane1 control fields
        vecs[9] = mk(3'b000, 48'h3, {6'd5, 6'd46}, 2'b11, {10'd55, 10'd60},
                     48'hC000_0000_0000, {10'd0, 10'd14}, 2'b00, 2'b00);

        rst = 1'b1;
        idle();
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;
        #1;
        chk("reset.in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // back-to-back stream; output at edge i belongs to vector i-1
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) begin
                drive(vecs[i]);
                #0 chk($sformatf("v%0d.in_ready", i), 64'(bus.in_ready), 64'd1);
            end else begin
                idle();
            end
            @(posedge clk);
            #1;
            if (i == 0) chk("v0.early_valid", 64'(bus.out_valid), 64'd0);
            else        check_out(vecs[i-1], $sformatf("v%0d", i - 1));
        end
        idle();
        @(posedge clk);
        #1;
        chk("drain.valid", 64'(bus.out_valid), 64'd0);

        // backpressure: A,B held, C stalled, then released
        bus.out_ready = 1'b0;
        drive(vecs[2]);
        #0 chk("bp.A.in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("bp.A.early_valid", 64'(bus.out_valid), 64'd0);
        drive(vecs[3]);
        #0 chk("bp.B.in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        check_out(vecs[2], "bp.A");
        drive(vecs[4]);
        #0 chk("bp.full.in_ready", 64'(bus.in_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_out(vecs[2], $sformatf("bp.hold%0d", k));
            chk($sformatf("bp.hold%0d.in_ready", k), 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp.release.in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        check_out(vecs[3], "bp.B");
        drive(vecs[5]);
        @(posedge clk);
        #1;
        check_out(vecs[4], "bp.C");
        idle();
        @(posedge clk);
        #1;
        check_out(vecs[5], "bp.D");
        @(posedge clk);
        #1;
        chk("bp.drain.valid", 64'(bus.out_valid), 64'd0);

        // reset with two beats in flight
        drive(vecs[2]);
        @(posedge clk);
        #1;
        drive(vecs[8]);
        @(posedge clk);
        #1;
        idle();
        chk("rst.inflight.valid", 64'(bus.out_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        check_reset_state("rst.mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst.after.in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst.after.valid", 64'(bus.out_valid), 64'd0);
        drive(vecs[5]);
        @(posedge clk);
        #1;
        idle();
        chk("rst.first.early_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check_out(vecs[5], "rst.first");
        @(posedge clk);
        #1;
        chk("rst.end.valid", 64'(bus.out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
